imem_responder: RTL
===================

Name: imem_responder

Overview:
- Instruction-memory responder: the memory side of the fetch-stage instruction read.
- Accepts PC read requests from fetch over a valid/ready handshake and returns 26-bit instruction words after a fixed latency.
- Absorbs decode-side stalls in a response FIFO and drops in-flight responses on a branch/PC-redirect flush.
- Provides a load port so the program image can be written before or while the core runs.

Parameters:
- ADDR_W, 32: request byte-address width.
- INSTR_W, 26: instruction word width.
- DEPTH_WORDS, 256: number of instruction words stored (power of two).
- LATENCY, 2: cycles from request acceptance to rsp_valid. Must be ≥1.
- FIFO_DEPTH, 4: response FIFO entries (power of two). Must be ≥ LATENCY.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  1  fetch presents a read request.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  ADDR_W  byte address (the PC).
- rsp_valid  out  1  response at FIFO head.
- rsp_ready  in  1  consumer takes the response (deasserted while decode is stalled).
- rsp_instr  out  INSTR_W  instruction word.
- rsp_err  out  1  response is for a misaligned or out-of-range address.
- flush  in  1  discard all in-flight and queued responses.
- ld_we  in  1  program-load write enable.
- ld_addr  in  log2(DEPTH_WORDS)  load word index.
- ld_data  in  INSTR_W  load data.
- outstanding  out  log2(FIFO_DEPTH)+1  in-flight plus queued responses.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pipeline valid bits cleared, FIFO pointers zeroed, outstanding=0.
  - rsp_valid=0, rsp_instr=0, rsp_err=0, req_ready=0 while reset is asserted.
  - Memory array is not reset.
  - Reset asserted mid-operation loses every in-flight response; there is no partial completion.
- Accept: req_valid & req_ready at a rising edge.
- req_ready = reset & ~flush & (outstanding < FIFO_DEPTH). This credit rule means the FIFO can never overflow.
- Address decode on accept:
  - idx = req_addr[log2(DEPTH_WORDS)+1:2].
  - err = (req_addr[1:0]≠0) | (req_addr[ADDR_W-1:log2(DEPTH_WORDS)+2]≠0).
  - If err, the returned word is 0 and rsp_err=1.
- Memory read samples the array at the accept edge. A load to the same idx on the same edge returns the OLD data; the new data is visible to requests accepted on later edges.
- Latency: a request accepted at edge k travels through a LATENCY-1 stage valid/data shift pipeline and is written to the FIFO at edge k+LATENCY-1. rsp_valid is high in the cycle after edge k+LATENCY-1, i.e. LATENCY cycles after acceptance, when the FIFO is otherwise empty. For LATENCY=1 the read result is written directly into the FIFO.
- FIFO:
  - rsp_valid = ~empty.
  - rsp_instr and rsp_err come from the head and are 0 when empty.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop is allowed at full or empty; with LATENCY=1 there is no combinational bypass.
- Ordering: responses leave strictly in acceptance order.
- outstanding counter:
  - +1 on accept, −1 on pop, unchanged when both occur.
  - Wraps never (bounded by the credit rule).
- Flush (flush=1 at an edge):
  - All pipeline valid bits cleared, FIFO emptied, outstanding=0.
  - Any pop in that cycle is ignored.
  - No request is accepted in the flush cycle (req_ready=0).
  - Requests may be accepted on the next edge.
- Load port: ld_we writes ld_data to mem[ld_addr] at the edge, independent of the request traffic and of flush.

Decomposition:
- Shared package (imem_pkg): INSTR_W default constant, the response struct rsp_t {instr[INSTR_W], err}, and the address-split helper function.
- One natural sub-module: resp_fifo, a parameterised synchronous FIFO of rsp_t with push, pop, clear (flush), full/empty and count outputs.
- The latency pipeline and memory array stay in the top level.

Test Plan:
- Load mem[0..3]=0x0000001,0x0000002,0x0000003,0x3FFFFFF. Stream addresses 0,4,8,12 back-to-back with rsp_ready=1 → responses 1,2,3,0x3FFFFFF, each exactly 2 cycles after accept, rsp_err=0, sustained 1 response/cycle.
- Hold rsp_ready=0 and issue requests 0,4,8,12,16 → exactly four are accepted, then req_ready=0 and outstanding=4. Release rsp_ready → four in-order responses, and req_ready returns 1 after the first pop.
- Request 0x2 (misaligned) and 0x400 (out of range, DEPTH 256) → rsp_instr=0 and rsp_err=1 for both; the neighbouring valid request 0x4 returns 2 with err=0.
- Accept 0,4, then flush one cycle later, then accept 8 → only the response 3 appears, with rsp_valid low in the cycles between; outstanding=0 right after the flush.
- Same edge: ld_we to idx 1 with 0x0ABCDEF and request addr 4 → returns 2. The next request to addr 4 returns 0x0ABCDEF.
- Assert reset low while 3 responses are queued and 1 is in flight → rsp_valid=0, outstanding=0 and req_ready=0 immediately (asynchronous). After release, mem contents are intact: request 0 returns 1.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared types and helpers for the instruction-memory responder.
// The address-range helper works on a zero-extended address so one function serves any ADDR_W.
package imem_responder_pkg;

  localparam int IMEM_INSTR_W = 26;

  typedef struct packed {
    logic [IMEM_INSTR_W-1:0] instr;
    logic                    err;
  } rsp_t;

  // A PC is bad when it is not word aligned or has any bit set above the word-index field.
  function automatic logic addr_bad(input logic [63:0] addr,
                                    input int          addr_w,
                                    input int          idx_w);
    logic bad;
    bad = |addr[1:0];
    for (int i = 2; i < 64; i++) begin
      if ((i >= idx_w + 2) && (i < addr_w)) begin
        bad = bad | addr[i];
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction-memory responder: request, response, flush, load and occupancy.
// Handshake: a transfer happens on a rising edge where valid & ready are both high; valid must not wait on ready.
interface imem_responder_if #(
  parameter int ADDR_W      = 32,
  parameter int INSTR_W     = 26,
  parameter int DEPTH_WORDS = 256,
  parameter int FIFO_DEPTH  = 4
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  req_addr;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [INSTR_W-1:0] rsp_instr;
  logic               rsp_err;
  logic               flush;
  logic               ld_we;
  logic [IDX_W-1:0]   ld_addr;
  logic [INSTR_W-1:0] ld_data;
  logic [CNT_W-1:0]   outstanding;

  modport master (
    output req_valid, req_addr, rsp_ready, flush, ld_we, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_err, outstanding
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, ld_we, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_instr, rsp_err, outstanding
  );

endinterface

// File: rtl/imem_responder_resp_fifo.sv
// Synchronous response FIFO with a clear that empties it in one edge and dominates push/pop.
// The head reads as all-zero while empty so downstream never sees stale data.
module imem_responder_resp_fifo
  import imem_responder_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = rsp_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_eff;
  logic             pop_eff;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign count_o  = count_q;
  assign pop_eff  = pop_i & ~empty_o;
  // A full FIFO may still take a push when the head leaves on the same edge.
  assign push_eff = push_i & (~full_o | pop_eff);
  assign data_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= bump(wr_ptr_q);
      if (pop_eff)  rd_ptr_q <= bump(rd_ptr_q);
      count_q <= count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff && !clear_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: PC reads with fixed latency, stall-absorbing response FIFO,
// flush of in-flight work, and a program-load write port into the word array.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int INSTR_W     = IMEM_INSTR_W,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  imem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               err;
  } word_rsp_t;

  logic [INSTR_W-1:0] mem_q [DEPTH_WORDS];
  logic [CNT_W-1:0]   outstanding_q;
  logic [CNT_W-1:0]   outstanding_d;
  logic [IDX_W-1:0]   rd_idx;
  logic               rd_err;
  word_rsp_t          rd_rsp;
  logic               accept;
  logic               pop;
  logic               push;
  word_rsp_t          push_rsp;
  word_rsp_t          head;
  logic               fifo_empty;
  logic               fifo_full;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_fifo_status;

  // Credits are counted from acceptance, so the FIFO always has room when the pipeline delivers.
  assign bus.req_ready   = reset & ~bus.flush & (outstanding_q < CNT_W'(FIFO_DEPTH));
  assign accept          = bus.req_valid & bus.req_ready;
  assign pop             = bus.rsp_valid & bus.rsp_ready;
  assign bus.outstanding = outstanding_q;
  assign bus.rsp_valid   = ~fifo_empty;
  assign bus.rsp_instr   = head.instr;
  assign bus.rsp_err     = head.err;

  assign rd_idx = bus.req_addr[IDX_W+1:2];
  assign rd_err = addr_bad(64'(bus.req_addr), ADDR_W, IDX_W);

  always_comb begin
    rd_rsp       = '0;
    rd_rsp.err   = rd_err;
    rd_rsp.instr = rd_err ? '0 : mem_q[rd_idx];
  end

  // The array is deliberately not reset so a loaded program survives a core reset.
  always_ff @(posedge clk) begin
    if (bus.ld_we) begin
      mem_q[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (bus.flush) begin
      outstanding_d = '0;
    end else if (accept && !pop) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!accept && pop) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  if (LATENCY == 1) begin : g_lat1
    assign push     = accept;
    assign push_rsp = rd_rsp;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv_q;
    word_rsp_t          pd_q [LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pv_q <= '0;
      end else if (bus.flush) begin
        pv_q <= '0;
      end else begin
        pv_q[0] <= accept;
        for (int i = 1; i < LATENCY - 1; i++) begin
          pv_q[i] <= pv_q[i-1];
        end
      end
    end

    // Data stages follow the valid bits; the array is sampled at the accept edge.
    always_ff @(posedge clk) begin
      pd_q[0] <= rd_rsp;
      for (int i = 1; i < LATENCY - 1; i++) begin
        pd_q[i] <= pd_q[i-1];
      end
    end

    assign push     = pv_q[LATENCY-2];
    assign push_rsp = pd_q[LATENCY-2];
  end

  imem_responder_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (word_rsp_t)
  ) u_resp_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (bus.flush),
    .push_i  (push),
    .data_i  (push_rsp),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign unused_fifo_status = ^{fifo_full, fifo_count};

endmodule
